// File: rtl/line_clear_engine_if.sv
// Port bundle for the line-clear engine: control pulses, status and the column-RAM bus.
interface line_clear_engine_if #(
  parameter int COLS = 10,
  parameter int CW   = 24
);
  logic                 start;
  logic                 wipe;
  logic [COLS*CW-1:0]   rd_data;
  logic [4:0]           ram_row;
  logic [COLS*CW-1:0]   wr_data;
  logic [COLS-1:0]      we;
  logic                 busy;
  logic                 done;
  logic [4:0]           lines;
  logic [9:0]           total_lines;

  modport master (
    output start, wipe, rd_data,
    input  ram_row, wr_data, we, busy, done, lines, total_lines
  );

  modport slave (
    input  start, wipe, rd_data,
    output ram_row, wr_data, we, busy, done, lines, total_lines
  );
endinterface

// File: rtl/line_clear_engine.sv
// Scans the playfield bottom-up for full rows, collapses each one by shifting the rows
// above it down, and zeroes the whole board on a wipe request.
module line_clear_engine #(
  parameter int COLS = 10,
  parameter int ROWS = 20,
  parameter int CW   = 24
) (
  input  logic               clk,
  input  logic               rst,
  line_clear_engine_if.slave bus
);
  typedef enum logic [3:0] {IDLE, RD, EV, SH_RD, SH_WR, SH_WT, CLR0, WIPE, DONE} state_t;

  localparam logic [4:0] LAST = 5'(ROWS - 1);

  state_t             state, state_n;
  logic [4:0]         row, row_n, k, k_n;
  logic [4:0]         lines, lines_n;
  logic [9:0]         total, total_n;
  logic [4:0]         ram_row, ram_row_n;
  logic [COLS*CW-1:0] wr_data, wr_data_n;
  logic [COLS-1:0]    we, we_n;
  logic               full;

  always_comb begin
    full = 1'b1;
    for (int i = 0; i < COLS; i++) full = full & (|bus.rd_data[CW*i +: CW]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row     <= '0;
      k       <= '0;
      lines   <= '0;
      total   <= '0;
      ram_row <= '0;
      wr_data <= '0;
      we      <= '0;
    end else begin
      state   <= state_n;
      row     <= row_n;
      k       <= k_n;
      lines   <= lines_n;
      total   <= total_n;
      ram_row <= ram_row_n;
      wr_data <= wr_data_n;
      we      <= we_n;
    end
  end

  always_comb begin
    state_n = state;
    row_n   = row;
    k_n     = k;
    lines_n = lines;
    total_n = total;
    case (state)
      IDLE:
        if (bus.wipe) begin
          state_n = WIPE;
          row_n   = '0;
          total_n = '0;
        end else if (bus.start) begin
          state_n = RD;
          row_n   = LAST;
          lines_n = '0;
        end
      RD: state_n = EV;
      EV:
        if (full) begin
          lines_n = lines + 5'd1;
          if (total != 10'h3FF) total_n = total + 10'd1;
          k_n     = row;
          state_n = (row == '0) ? CLR0 : SH_RD;
        end else if (row == '0) begin
          state_n = DONE;
        end else begin
          row_n   = row - 5'd1;
          state_n = RD;
        end
      SH_RD: state_n = SH_WR;
      SH_WR: state_n = SH_WT;
      SH_WT: begin
        k_n     = k - 5'd1;
        state_n = (k == 5'd1) ? CLR0 : SH_RD;
      end
      // rescan the same row: the content above has just dropped into it
      CLR0: state_n = RD;
      WIPE:
        if (row == LAST) state_n = DONE;
        else             row_n   = row + 5'd1;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // RAM-side outputs are registered from the state being entered, so they are
  // presented to the RAM during that state.
  always_comb begin
    ram_row_n = ram_row;
    wr_data_n = wr_data;
    we_n      = '0;
    case (state_n)
      RD:    ram_row_n = row_n;
      SH_RD: ram_row_n = k_n - 5'd1;
      SH_WT: begin
        ram_row_n = k;
        wr_data_n = bus.rd_data;
        we_n      = '1;
      end
      CLR0: begin
        ram_row_n = '0;
        wr_data_n = '0;
        we_n      = '1;
      end
      WIPE: begin
        ram_row_n = row_n;
        wr_data_n = '0;
        we_n      = '1;
      end
      default: ;
    endcase
  end

  assign bus.ram_row     = ram_row;
  assign bus.wr_data     = wr_data;
  assign bus.we          = we;
  assign bus.busy        = (state != IDLE) && (state != DONE);
  assign bus.done        = (state == DONE);
  assign bus.lines       = lines;
  assign bus.total_lines = total;
endmodule

// File: tb/tb_line_clear_engine.sv
// Bench for line_clear_engine: behavioural column RAM, board-compaction model and done scoreboard.
module tb_line_clear_engine;
  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int CW   = 24;
  localparam int W    = COLS * CW;

  typedef struct {int cyc; int lines; int total;} exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_clear_engine_if #(.COLS(COLS), .CW(CW)) bus();
  line_clear_engine #(.COLS(COLS), .ROWS(ROWS), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [CW-1:0] mem [ROWS][COLS];
  logic [CW-1:0] eb  [ROWS][COLS];
  logic [W-1:0]  rd_q = '0;
  assign bus.rd_data = rd_q;

  // synchronous-read column RAMs; read returns the pre-write contents
  always @(posedge clk) begin
    logic [W-1:0] r;
    r = '0;
    if (int'(bus.ram_row) < ROWS) begin
      for (int i = 0; i < COLS; i++) r[CW*i +: CW] = mem[bus.ram_row][i];
      for (int i = 0; i < COLS; i++)
        if (bus.we[i]) mem[bus.ram_row][i] = bus.wr_data[CW*i +: CW];
    end
    rd_q <= r;
  end

  int   n_cmp = 0, n_bad = 0;
  exp_t sbq[$];
  int   tick = 0, t0 = 0, done_cnt = 0, busy_cnt = 0, we_cnt = 0, etot = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) tick++;

  always @(negedge clk) begin
    if (bus.busy) busy_cnt++;
    if (|bus.we) we_cnt++;
    if (bus.done) begin
      done_cnt++;
      if (sbq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_cycle", tick - t0, e.cyc);
        if (e.lines >= 0) chk("lines", bus.lines, e.lines);
        chk("total_lines", bus.total_lines, e.total);
      end
    end
  end

  function automatic logic [W-1:0] pack_mem(input int r);
    logic [W-1:0] v;
    for (int c = 0; c < COLS; c++) v[CW*c +: CW] = mem[r][c];
    return v;
  endfunction

  function automatic logic [W-1:0] pack_eb(input int r);
    logic [W-1:0] v;
    for (int c = 0; c < COLS; c++) v[CW*c +: CW] = eb[r][c];
    return v;
  endfunction

  task automatic clear_mem();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) mem[r][c] = '0;
  endtask

  task automatic fill_row(input int r, input int ncols);
    for (int c = 0; c < ncols; c++) mem[r][c] = CW'($urandom_range(1, 32'hFFFFFF));
  endtask

  // gravity compaction; each full row costs its evaluation, a 3-cycle shift per row
  // above its landing slot and one row-0 clear, on top of one 2-cycle visit per final row
  task automatic model(output int ecyc, output int nl);
    int  dst;
    bit  f;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) eb[r][c] = '0;
    dst  = ROWS - 1;
    ecyc = 1 + 2 * ROWS;
    nl   = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      f = 1'b1;
      for (int c = 0; c < COLS; c++) if (mem[r][c] == '0) f = 1'b0;
      if (f) begin
        nl++;
        ecyc += 3 + 3 * dst;
      end else begin
        for (int c = 0; c < COLS; c++) eb[dst][c] = mem[r][c];
        dst--;
      end
    end
  endtask

  task automatic run(input bit wp, output int bc, output int wc, output int dc);
    exp_t e;
    int   ecyc, nl, d0;
    if (wp) begin
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) eb[r][c] = '0;
      e.cyc = ROWS + 1; e.lines = -1; etot = 0;
    end else begin
      model(ecyc, nl);
      e.cyc = ecyc; e.lines = nl;
      etot  = (etot + nl > 1023) ? 1023 : etot + nl;
    end
    e.total = etot;
    sbq.push_back(e);
    @(negedge clk);
    d0 = done_cnt; busy_cnt = 0; we_cnt = 0; t0 = tick;
    bus.start = 1'b1;
    bus.wipe  = wp;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.wipe = 1'b0;
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
    if (done_cnt == d0) begin
      chk("done_timeout", 0, 1);
      sbq.delete();
    end
    repeat (4) @(negedge clk);
    bc = busy_cnt; wc = we_cnt; dc = done_cnt - d0;
    for (int r = 0; r < ROWS; r++) chk($sformatf("board_row%0d", r), pack_mem(r), pack_eb(r));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bc, wc, dc, d0;
    rst = 1'b1; bus.start = 1'b0; bus.wipe = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_row", bus.ram_row, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_we", bus.we, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_lines", bus.lines, 0);
    chk("rst_total", bus.total_lines, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // empty board
    run(1'b0, bc, wc, dc);
    chk("empty_busy_cycles", bc, 2 * ROWS);
    chk("empty_we_cycles", wc, 0);

    // single full bottom row with one cell resting on it
    clear_mem();
    fill_row(19, COLS);
    mem[18][3] = 24'h66B2FF;
    run(1'b0, bc, wc, dc);
    chk("single_done_pulses", dc, 1);

    // wipe together with start over a cluttered board
    for (int r = 5; r < ROWS; r++) fill_row(r, $urandom_range(1, COLS));
    run(1'b1, bc, wc, dc);
    chk("wipe_busy_cycles", bc, ROWS);
    chk("wipe_we_cycles", wc, ROWS);

    // four stacked full rows
    clear_mem();
    for (int r = 16; r < ROWS; r++) fill_row(r, COLS);
    run(1'b0, bc, wc, dc);
    chk("tetris_done_pulses", dc, 1);

    // full rows split by a partial one
    clear_mem();
    fill_row(19, COLS);
    fill_row(18, COLS - 1);
    fill_row(17, COLS);
    fill_row(16, 4);
    run(1'b0, bc, wc, dc);
    chk("split_done_pulses", dc, 1);

    // reset while the first shift is in SH_WR (cycle 4)
    clear_mem();
    fill_row(19, COLS);
    fill_row(18, 2);
    @(negedge clk);
    d0 = done_cnt;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_we", bus.we, 0);
    chk("midrst_lines", bus.lines, 0);
    etot = 0;
    repeat (50) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    run(1'b0, bc, wc, dc);
    chk("after_rst_done_pulses", dc, 1);

    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
